// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency-meter measurement sequencer.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        GATE   = 2'd2,
        SETTLE = 2'd3
    } state_e;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_GATE_CYCLES = 50_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module gate_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          done
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer: clears and gates the event counter, then captures
// the settled count and offers it on a VALID/ACK handshake.
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             nCLR,
    input  logic             START,
    input  logic             CONT,
    input  logic [WIDTH-1:0] DIN,
    input  logic             ACK,
    output logic             CNT_nCLR,
    output logic             CNT_EN,
    output logic [WIDTH-1:0] DOUT,
    output logic             VALID,
    output logic             OVERRUN,
    output logic             BUSY
);

    localparam int MAXC = max3(GATE_CYCLES, CLR_CYCLES, SETTLE_CYCLES);
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] CLR_LD    = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LD   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic               cnt_nclr_q, cnt_nclr_d;
    logic               cnt_en_q, cnt_en_d;
    logic               busy_q, busy_d;
    logic               cap_q, cap_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

    logic               tmr_load;
    logic [TW-1:0]      tmr_load_val;
    logic               tmr_done;

    gate_timer #(
        .TW(TW)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (nCLR),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // Next state and timer reload on every state entry.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state_q)
            IDLE: begin
                if (START || CONT) begin
                    state_d      = CLEAR;
                    tmr_load     = 1'b1;
                    tmr_load_val = CLR_LD;
                end
            end
            CLEAR: begin
                if (tmr_done) begin
                    state_d      = GATE;
                    tmr_load     = 1'b1;
                    tmr_load_val = GATE_LD;
                end
            end
            GATE: begin
                if (tmr_done) begin
                    state_d      = SETTLE;
                    tmr_load     = 1'b1;
                    tmr_load_val = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (tmr_done) begin
                    if (CONT) begin
                        state_d      = CLEAR;
                        tmr_load     = 1'b1;
                        tmr_load_val = CLR_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs trail the state by one edge, so every output window is an
    // exact copy of the corresponding state window and the gate never jitters.
    always_comb begin
        cnt_nclr_d = (state_q != CLEAR);
        cnt_en_d   = (state_q == GATE);
        busy_d     = (state_q != IDLE);
        cap_d      = (state_q == SETTLE) && tmr_done;

        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (ACK && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        // A capture beats a coincident ACK; only an unacknowledged result counts as lost.
        if (cap_q) begin
            dout_d  = DIN;
            valid_d = 1'b1;
            if (valid_q && !ACK) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_q    <= IDLE;
            cnt_nclr_q <= 1'b0;
            cnt_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            cap_q      <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_nclr_q <= cnt_nclr_d;
            cnt_en_q   <= cnt_en_d;
            busy_q     <= busy_d;
            cap_q      <= cap_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign CNT_nCLR = cnt_nclr_q;
    assign CNT_EN   = cnt_en_q;
    assign BUSY     = busy_q;
    assign DOUT     = dout_q;
    assign VALID    = valid_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Scoreboard bench for freq_gate_ctrl with a short gate (10/2/3 cycles).
module tb_freq_gate_ctrl;

    logic        CLK = 1'b0;
    logic        nCLR;
    logic        START;
    logic        CONT;
    logic [31:0] DIN;
    logic        ACK;
    logic        CNT_nCLR;
    logic        CNT_EN;
    logic [31:0] DOUT;
    logic        VALID;
    logic        OVERRUN;
    logic        BUSY;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int k;
    int ncap0;

    logic [31:0] exp_q[$];
    int          cap_cycs[$];
    logic        prev_valid = 1'b0;
    logic [31:0] prev_dout = '0;

    freq_gate_ctrl #(
        .WIDTH         (32),
        .GATE_CYCLES   (10),
        .CLR_CYCLES    (2),
        .SETTLE_CYCLES (3)
    ) dut (
        .CLK      (CLK),
        .nCLR     (nCLR),
        .START    (START),
        .CONT     (CONT),
        .DIN      (DIN),
        .ACK      (ACK),
        .CNT_nCLR (CNT_nCLR),
        .CNT_EN   (CNT_EN),
        .DOUT     (DOUT),
        .VALID    (VALID),
        .OVERRUN  (OVERRUN),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // A new result shows up as VALID rising or DOUT changing while VALID is held.
    always @(negedge CLK) begin
        if (nCLR && VALID && (!prev_valid || DOUT != prev_dout)) begin
            cap_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("sb_pending", 64'(exp_q.size()), 64'(1));
            end else begin
                chk("sb_dout", 64'(DOUT), 64'(exp_q.pop_front()));
            end
        end
        prev_valid = VALID;
        prev_dout  = DOUT;
    end

    initial begin
        nCLR = 1'b0; START = 1'b0; CONT = 1'b0; ACK = 1'b0; DIN = '0;
        repeat (3) tick();
        chk("rst_nclr",    64'(CNT_nCLR), 64'(0));
        chk("rst_en",      64'(CNT_EN),   64'(0));
        chk("rst_dout",    64'(DOUT),     64'(0));
        chk("rst_valid",   64'(VALID),    64'(0));
        chk("rst_overrun", 64'(OVERRUN),  64'(0));
        chk("rst_busy",    64'(BUSY),     64'(0));
        #2 nCLR = 1'b1;
        tick();
        chk("rel_nclr", 64'(CNT_nCLR), 64'(1));
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_en",    64'(CNT_EN), 64'(0));
            chk("idle_valid", 64'(VALID),  64'(0));
            chk("idle_busy",  64'(BUSY),   64'(0));
        end

        // Single shot; DIN only carries the real value around the capture edge.
        DIN = 32'hDEAD_BEEF;
        START = 1'b1;
        exp_q.push_back(32'h0000_1234);
        tick();
        START = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk("ss_nclr",  64'(CNT_nCLR), 64'(!(e <= 2)));
            chk("ss_en",    64'(CNT_EN),   64'(e >= 3 && e <= 12));
            chk("ss_busy",  64'(BUSY),     64'(e <= 15));
            chk("ss_valid", 64'(VALID),    64'(e >= 16));
            if (e == 12) DIN = 32'h0000_1234;
            if (e == 16) DIN = 32'hDEAD_BEEF;
        end
        repeat (4) tick();
        chk("hs_valid_held", 64'(VALID), 64'(1));
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("hs_valid_clr", 64'(VALID),   64'(0));
        chk("hs_dout_keep", 64'(DOUT),    64'(32'h1234));
        chk("hs_overrun",   64'(OVERRUN), 64'(0));
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("ack_novalid_valid", 64'(VALID),   64'(0));
        chk("ack_novalid_ovr",   64'(OVERRUN), 64'(0));
        chk("ack_novalid_dout",  64'(DOUT),    64'(32'h1234));

        // START pulses while busy must not restart or add a measurement.
        START = 1'b1;
        exp_q.push_back(32'h0000_ABCD);
        tick();
        START = 1'b0;
        k = cyc;
        for (int e = 1; e <= 20; e++) begin
            tick();
            START = (e == 5 || e == 13);
            chk("ign_busy", 64'(BUSY),   64'(e <= 15));
            chk("ign_en",   64'(CNT_EN), 64'(e >= 3 && e <= 12));
            if (e == 12) DIN = 32'h0000_ABCD;
            if (e == 16) DIN = 32'hDEAD_BEEF;
        end
        START = 1'b0;
        if (cap_cycs.size() > 0) chk("ign_cap_cyc", 64'(cap_cycs[$]), 64'(k + 16));
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("ign_ack_valid", 64'(VALID), 64'(0));

        // Continuous with no ACK: second capture overruns the first.
        ncap0 = cap_cycs.size();
        DIN = 32'd5;
        CONT = 1'b1;
        exp_q.push_back(32'd5);
        tick();
        k = cyc;
        for (int e = 1; e <= 35; e++) begin
            tick();
            if (e == 16) begin
                chk("cont_busy1",    64'(BUSY),    64'(1));
                chk("cont_valid1",   64'(VALID),   64'(1));
                chk("cont_overrun1", 64'(OVERRUN), 64'(0));
                DIN = 32'd7;
                exp_q.push_back(32'd7);
            end
            if (e == 20) CONT = 1'b0;
            if (e == 31) begin
                chk("cont_valid2",   64'(VALID),   64'(1));
                chk("cont_overrun2", 64'(OVERRUN), 64'(1));
                chk("cont_busy2",    64'(BUSY),    64'(0));
                chk("cont_dout2",    64'(DOUT),    64'(7));
            end
        end
        chk("cont_ncaps", 64'(cap_cycs.size() - ncap0), 64'(2));
        if (cap_cycs.size() >= ncap0 + 2) begin
            chk("cont_cap1_cyc", 64'(cap_cycs[ncap0]), 64'(k + 16));
            chk("cont_period",   64'(cap_cycs[ncap0 + 1] - cap_cycs[ncap0]), 64'(15));
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("cont_ack_valid",   64'(VALID),   64'(0));
        chk("cont_ack_overrun", 64'(OVERRUN), 64'(0));

        // Capture and ACK on the same edge: capture wins, no overrun.
        DIN = 32'h11;
        START = 1'b1;
        exp_q.push_back(32'h11);
        tick();
        START = 1'b0;
        repeat (20) tick();
        chk("sim_pre_valid", 64'(VALID), 64'(1));
        DIN = 32'h22;
        START = 1'b1;
        exp_q.push_back(32'h22);
        tick();
        START = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 15) ACK = 1'b1;
            if (e == 16) begin
                ACK = 1'b0;
                chk("sim_valid",   64'(VALID),   64'(1));
                chk("sim_overrun", 64'(OVERRUN), 64'(0));
                chk("sim_dout",    64'(DOUT),    64'(32'h22));
            end
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("sim_ack_valid", 64'(VALID), 64'(0));

        // Reset in the middle of the gate discards the measurement.
        DIN = 32'h99;
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (6) tick();
        chk("mid_en_before", 64'(CNT_EN), 64'(1));
        nCLR = 1'b0;
        #1;
        chk("mid_en",      64'(CNT_EN),   64'(0));
        chk("mid_nclr",    64'(CNT_nCLR), 64'(0));
        chk("mid_busy",    64'(BUSY),     64'(0));
        chk("mid_valid",   64'(VALID),    64'(0));
        chk("mid_dout",    64'(DOUT),     64'(0));
        chk("mid_overrun", 64'(OVERRUN),  64'(0));
        repeat (2) tick();
        nCLR = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_busy",  64'(BUSY),   64'(0));
            chk("post_valid", 64'(VALID),  64'(0));
        end

        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
